// File: rtl/lock_attempt_ctrl.sv
// lock_attempt_ctrl: keypad entry sequencer for the serial combination lock.
// Optional feature macro LOCK_ALARM_EN adds a sticky alarm output set on lockout entry.
module lock_attempt_ctrl #(
   parameter int                  CODE_LEN       = 4,
   parameter logic [CODE_LEN-1:0] DEFAULT_CODE   = 4'b1011,
   parameter int                  MAX_FAIL       = 3,
   parameter int                  UNLOCK_CYCLES  = 8,
   parameter int                  LOCKOUT_CYCLES = 16
) (
   input  logic                              clock,
   input  logic                              resetphase,
   input  logic                              bit_valid,
   input  logic                              bit_in,
   input  logic                              abort,
   input  logic                              prog_en,
   input  logic [CODE_LEN-1:0]               prog_code,
   output logic                              unlocked,
   output logic                              locked_out,
   output logic                              err,
   output logic [1:0]                        state,
`ifdef LOCK_ALARM_EN
   output logic                              alarm,
`endif
   output logic [$clog2(MAX_FAIL+1)-1:0]     fail_cnt
);

   localparam int FW   = $clog2(MAX_FAIL + 1);
   localparam int CW   = $clog2(CODE_LEN + 1);
   localparam int TMAX = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES : LOCKOUT_CYCLES;
   localparam int TW   = $clog2(TMAX + 1);
   localparam int SW   = CODE_LEN - 1;

   typedef enum logic [1:0] {
      IDLE    = 2'b00,
      ENTRY   = 2'b01,
      OPEN    = 2'b10,
      LOCKOUT = 2'b11
   } state_t;

   state_t              state_q, state_d;
   logic [CODE_LEN-1:0] code_q, code_d;
   logic [SW-1:0]       shift_q, shift_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic [TW-1:0]       timer_q, timer_d;
   logic [FW-1:0]       fail_q, fail_d;
   logic                unlocked_q, unlocked_d;
   logic                locked_out_q, locked_out_d;
   logic                err_q, err_d;
   logic [CODE_LEN-1:0] attempt;
   logic [FW-1:0]       fail_inc;

   // The final bit is compared straight off the input, so the shift register
   // only ever needs to hold the first CODE_LEN-1 bits.
   assign attempt  = {shift_q, bit_in};
   assign fail_inc = (fail_q == FW'(MAX_FAIL)) ? fail_q : fail_q + 1'b1;

   always_comb begin
      state_d = state_q;
      code_d  = code_q;
      shift_d = shift_q;
      cnt_d   = cnt_q;
      timer_d = timer_q;
      fail_d  = fail_q;
      err_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (!abort && bit_valid) begin
               shift_d = SW'(bit_in);
               cnt_d   = CW'(1);
               state_d = ENTRY;
            end
         end
         ENTRY: begin
            if (abort) begin
               shift_d = '0;
               cnt_d   = '0;
               state_d = IDLE;
            end else if (bit_valid) begin
               if (cnt_q == CW'(CODE_LEN - 1)) begin
                  shift_d = '0;
                  cnt_d   = '0;
                  if (attempt == code_q) begin
                     state_d = OPEN;
                     fail_d  = '0;
                     timer_d = TW'(UNLOCK_CYCLES);
                  end else begin
                     err_d  = 1'b1;
                     fail_d = fail_inc;
                     if (fail_inc == FW'(MAX_FAIL)) begin
                        state_d = LOCKOUT;
                        timer_d = TW'(LOCKOUT_CYCLES);
                     end else begin
                        state_d = IDLE;
                     end
                  end
               end else begin
                  shift_d = SW'({shift_q, bit_in});
                  cnt_d   = cnt_q + 1'b1;
               end
            end
         end
         OPEN: begin
            if (prog_en) code_d = prog_code;
            timer_d = timer_q - 1'b1;
            if (abort || timer_q == TW'(1)) begin
               state_d = IDLE;
               timer_d = '0;
            end
         end
         LOCKOUT: begin
            timer_d = timer_q - 1'b1;
            if (timer_q == TW'(1)) begin
               state_d = IDLE;
               timer_d = '0;
               fail_d  = '0;
            end
         end
         default: state_d = IDLE;
      endcase
      unlocked_d   = (state_d == OPEN);
      locked_out_d = (state_d == LOCKOUT);
   end

   always_ff @(posedge clock) begin
      if (resetphase) begin
         state_q      <= IDLE;
         code_q       <= DEFAULT_CODE;
         shift_q      <= '0;
         cnt_q        <= '0;
         timer_q      <= '0;
         fail_q       <= '0;
         unlocked_q   <= 1'b0;
         locked_out_q <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         code_q       <= code_d;
         shift_q      <= shift_d;
         cnt_q        <= cnt_d;
         timer_q      <= timer_d;
         fail_q       <= fail_d;
         unlocked_q   <= unlocked_d;
         locked_out_q <= locked_out_d;
         err_q        <= err_d;
      end
   end

`ifdef LOCK_ALARM_EN
   logic alarm_q, alarm_d;

   // Sticky from lockout entry until the next successful unlock.
   always_comb begin
      alarm_d = alarm_q;
      if (state_d == LOCKOUT && state_q != LOCKOUT) alarm_d = 1'b1;
      else if (state_d == OPEN && state_q != OPEN) alarm_d = 1'b0;
   end

   always_ff @(posedge clock) begin
      if (resetphase) alarm_q <= 1'b0;
      else            alarm_q <= alarm_d;
   end

   assign alarm = alarm_q;
`endif

   assign state      = state_q;
   assign unlocked   = unlocked_q;
   assign locked_out = locked_out_q;
   assign err        = err_q;
   assign fail_cnt   = fail_q;

endmodule

// File: tb/tb_lock_attempt_ctrl.sv
// tb_lock_attempt_ctrl: directed and randomized checks of lock_attempt_ctrl
// against a queue-based behavioural model of the keypad lock.
`timescale 1ns/1ps
module tb_lock_attempt_ctrl;

   localparam int CODE_LEN       = 4;
   localparam int MAX_FAIL       = 3;
   localparam int UNLOCK_CYCLES  = 8;
   localparam int LOCKOUT_CYCLES = 16;
`ifdef LOCK_ALARM_EN
   localparam int OW = 8;
`else
   localparam int OW = 7;
`endif

   typedef struct packed {
      logic       bv;
      logic       bi;
      logic       ab;
      logic       pe;
      logic [3:0] pc;
      logic       rst;
   } stim_t;

   logic       clock = 1'b0;
   logic       resetphase = 1'b1;
   logic       bit_valid = 1'b0;
   logic       bit_in = 1'b0;
   logic       abort = 1'b0;
   logic       prog_en = 1'b0;
   logic [3:0] prog_code = 4'b0000;
   logic       unlocked, locked_out, err;
   logic [1:0] state;
   logic [1:0] fail_cnt;
`ifdef LOCK_ALARM_EN
   logic       alarm;
`endif

   lock_attempt_ctrl dut (
      .clock      (clock),
      .resetphase (resetphase),
      .bit_valid  (bit_valid),
      .bit_in     (bit_in),
      .abort      (abort),
      .prog_en    (prog_en),
      .prog_code  (prog_code),
      .unlocked   (unlocked),
      .locked_out (locked_out),
      .err        (err),
      .state      (state),
`ifdef LOCK_ALARM_EN
      .alarm      (alarm),
`endif
      .fail_cnt   (fail_cnt)
   );

   always #5 clock = ~clock;

   // Behavioural model: entered bits kept as a queue, timers as cycles remaining.
   logic       m_bits[$];
   logic [3:0] m_code = 4'b1011;
   int         m_state = 0;
   int         m_left = 0;
   int         m_fail = 0;
   logic       m_err = 1'b0;
`ifdef LOCK_ALARM_EN
   logic       m_alarm = 1'b0;
`endif

   logic [OW-1:0] exp_q[$];
   stim_t         stim_q[$];
   int            n_checks = 0;
   int            n_pass = 0;

   function automatic logic [OW-1:0] exp_vec();
      logic [1:0] st;
      logic [1:0] fc;
      st = m_state[1:0];
      fc = m_fail[1:0];
`ifdef LOCK_ALARM_EN
      return {st, m_state == 2, m_state == 3, m_err, fc, m_alarm};
`else
      return {st, m_state == 2, m_state == 3, m_err, fc};
`endif
   endfunction

   function automatic logic [OW-1:0] dut_vec();
`ifdef LOCK_ALARM_EN
      return {state, unlocked, locked_out, err, fail_cnt, alarm};
`else
      return {state, unlocked, locked_out, err, fail_cnt};
`endif
   endfunction

   task automatic model_step(input stim_t s);
      logic [3:0] val;
      m_err = 1'b0;
      if (s.rst) begin
         m_state = 0;
         m_code  = 4'b1011;
         m_bits.delete();
         m_left  = 0;
         m_fail  = 0;
`ifdef LOCK_ALARM_EN
         m_alarm = 1'b0;
`endif
      end else begin
         case (m_state)
            0, 1: begin
               if (s.ab) begin
                  m_bits.delete();
                  m_state = 0;
               end else if (s.bv) begin
                  m_bits.push_back(s.bi);
                  if (m_bits.size() == CODE_LEN) begin
                     val = 4'b0000;
                     foreach (m_bits[k]) val = {val[2:0], m_bits[k]};
                     m_bits.delete();
                     if (val == m_code) begin
                        m_state = 2;
                        m_left  = UNLOCK_CYCLES;
                        m_fail  = 0;
`ifdef LOCK_ALARM_EN
                        m_alarm = 1'b0;
`endif
                     end else begin
                        m_err = 1'b1;
                        if (m_fail < MAX_FAIL) m_fail++;
                        if (m_fail == MAX_FAIL) begin
                           m_state = 3;
                           m_left  = LOCKOUT_CYCLES;
`ifdef LOCK_ALARM_EN
                           m_alarm = 1'b1;
`endif
                        end else begin
                           m_state = 0;
                        end
                     end
                  end else begin
                     m_state = 1;
                  end
               end
            end
            2: begin
               if (s.pe) m_code = s.pc;
               m_left--;
               if (s.ab || m_left == 0) m_state = 0;
            end
            3: begin
               m_left--;
               if (m_left == 0) begin
                  m_state = 0;
                  m_fail  = 0;
               end
            end
            default: m_state = 0;
         endcase
      end
      exp_q.push_back(exp_vec());
   endtask

   task automatic drive(input stim_t s);
      bit_valid  = s.bv;
      bit_in     = s.bi;
      abort      = s.ab;
      prog_en    = s.pe;
      prog_code  = s.pc;
      resetphase = s.rst;
      @(posedge clock);
      model_step(s);
      #1;
   endtask

   task automatic add(input logic bv, input logic bi, input logic ab, input logic pe,
                      input logic [3:0] pc, input logic rst);
      stim_t s;
      s.bv = bv; s.bi = bi; s.ab = ab; s.pe = pe; s.pc = pc; s.rst = rst;
      stim_q.push_back(s);
   endtask

   task automatic add_code(input logic [3:0] c);
      for (int b = 3; b >= 0; b--) add(1'b1, c[b], 1'b0, 1'b0, 4'b0000, 1'b0);
   endtask

   task automatic add_idle(input int n);
      for (int j = 0; j < n; j++) add(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0);
   endtask

   task automatic test_reset();
      stim_t s;
      logic [OW-1:0] e;
      int i;
      add(1'b1, 1'b1, 1'b1, 1'b1, 4'b1111, 1'b1);
      add_idle(0);
      add(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b1);
      i = 0;
      while (stim_q.size() > 0) begin
         s = stim_q.pop_front();
         drive(s);
         e = exp_q.pop_front();
         n_checks++;
         if (dut_vec() !== e) $display("FAIL reset step %0d: got %b expected %b", i, dut_vec(), e);
         else n_pass++;
         i++;
      end
      n_checks++;
      if ({state, unlocked, locked_out, err, fail_cnt} !== 7'b0)
         $display("FAIL reset_zero: got %b expected 0000000", {state, unlocked, locked_out, err, fail_cnt});
      else n_pass++;
   endtask

   task automatic test_unlock();
      stim_t s;
      logic [OW-1:0] e;
      int i, unl;
      add_code(4'b1011);
      add_idle(12);
      i = 0;
      unl = 0;
      while (stim_q.size() > 0) begin
         s = stim_q.pop_front();
         drive(s);
         e = exp_q.pop_front();
         n_checks++;
         if (dut_vec() !== e) $display("FAIL unlock step %0d: got %b expected %b", i, dut_vec(), e);
         else n_pass++;
         if (unlocked === 1'b1) unl++;
         if (i == 3) begin
            n_checks++;
            if (state !== 2'b10 || unlocked !== 1'b1)
               $display("FAIL unlock_open: got state %b unlocked %b expected 10 1", state, unlocked);
            else n_pass++;
         end
         i++;
      end
      n_checks++;
      if (unl !== UNLOCK_CYCLES) $display("FAIL unlock_len: got %0d expected %0d", unl, UNLOCK_CYCLES);
      else n_pass++;
      n_checks++;
      if (state !== 2'b00 || unlocked !== 1'b0 || fail_cnt !== 2'd0)
         $display("FAIL unlock_end: got %b %b %0d expected 00 0 0", state, unlocked, fail_cnt);
      else n_pass++;
   endtask

   task automatic test_fail_lockout();
      stim_t s;
      logic [OW-1:0] e;
      int i, errs, lo;
      add_code(4'b1001);
      add_idle(1);
      add_code(4'b1001);
      add_idle(1);
      add_code(4'b1001);
      for (int j = 0; j < LOCKOUT_CYCLES; j++)
         add(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             4'($urandom_range(0, 15)), 1'b0);
      add_idle(3);
      i = 0;
      errs = 0;
      lo = 0;
      while (stim_q.size() > 0) begin
         s = stim_q.pop_front();
         drive(s);
         e = exp_q.pop_front();
         n_checks++;
         if (dut_vec() !== e) $display("FAIL lockout step %0d: got %b expected %b", i, dut_vec(), e);
         else n_pass++;
         if (err === 1'b1) errs++;
         if (locked_out === 1'b1) lo++;
         if (i == 3) begin
            n_checks++;
            if (err !== 1'b1 || fail_cnt !== 2'd1 || state !== 2'b00)
               $display("FAIL first_fail: got err %b cnt %0d state %b expected 1 1 00", err, fail_cnt, state);
            else n_pass++;
         end
         i++;
      end
      n_checks++;
      if (errs !== 3) $display("FAIL err_pulses: got %0d expected 3", errs);
      else n_pass++;
      n_checks++;
      if (lo !== LOCKOUT_CYCLES) $display("FAIL lockout_len: got %0d expected %0d", lo, LOCKOUT_CYCLES);
      else n_pass++;
      n_checks++;
      if (state !== 2'b00 || fail_cnt !== 2'd0 || locked_out !== 1'b0)
         $display("FAIL lockout_end: got %b %0d %b expected 00 0 0", state, fail_cnt, locked_out);
      else n_pass++;
`ifdef LOCK_ALARM_EN
      n_checks++;
      if (alarm !== 1'b1) $display("FAIL alarm_sticky: got %b expected 1", alarm);
      else n_pass++;
`endif
   endtask

   task automatic test_abort();
      stim_t s;
      logic [OW-1:0] e;
      int i;
      add(1'b1, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0);
      add(1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0);
      add(1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0);
      add_code(4'b1011);
      add_idle(3);
      add(1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0);
      add_idle(2);
      i = 0;
      while (stim_q.size() > 0) begin
         s = stim_q.pop_front();
         drive(s);
         e = exp_q.pop_front();
         n_checks++;
         if (dut_vec() !== e) $display("FAIL abort step %0d: got %b expected %b", i, dut_vec(), e);
         else n_pass++;
         if (i == 2) begin
            n_checks++;
            if (state !== 2'b00 || err !== 1'b0 || fail_cnt !== 2'd0)
               $display("FAIL abort_entry: got %b %b %0d expected 00 0 0", state, err, fail_cnt);
            else n_pass++;
         end
         if (i == 6) begin
            n_checks++;
            if (state !== 2'b10 || unlocked !== 1'b1)
               $display("FAIL abort_reentry: got %b %b expected 10 1", state, unlocked);
            else n_pass++;
`ifdef LOCK_ALARM_EN
            n_checks++;
            if (alarm !== 1'b0) $display("FAIL alarm_clear: got %b expected 0", alarm);
            else n_pass++;
`endif
         end
         if (i == 10) begin
            n_checks++;
            if (state !== 2'b00 || unlocked !== 1'b0)
               $display("FAIL abort_open: got %b %b expected 00 0", state, unlocked);
            else n_pass++;
         end
         i++;
      end
   endtask

   task automatic test_program();
      stim_t s;
      logic [OW-1:0] e;
      int i, errs, opens;
      logic prev_u;
      add_code(4'b1011);
      add(1'b0, 1'b0, 1'b0, 1'b1, 4'b0110, 1'b0);
      add_idle(9);
      add_code(4'b1011);
      add_idle(1);
      add_code(4'b0110);
      add_idle(9);
      add(1'b0, 1'b0, 1'b0, 1'b1, 4'b1111, 1'b0);
      add_code(4'b0110);
      add_idle(9);
      i = 0;
      errs = 0;
      opens = 0;
      prev_u = unlocked;
      while (stim_q.size() > 0) begin
         s = stim_q.pop_front();
         drive(s);
         e = exp_q.pop_front();
         n_checks++;
         if (dut_vec() !== e) $display("FAIL program step %0d: got %b expected %b", i, dut_vec(), e);
         else n_pass++;
         if (err === 1'b1) errs++;
         if (unlocked === 1'b1 && prev_u !== 1'b1) opens++;
         prev_u = unlocked;
         i++;
      end
      n_checks++;
      if (errs !== 1) $display("FAIL program_errs: got %0d expected 1", errs);
      else n_pass++;
      n_checks++;
      if (opens !== 3) $display("FAIL program_opens: got %0d expected 3", opens);
      else n_pass++;
   endtask

   task automatic test_reset_mid();
      stim_t s;
      logic [OW-1:0] e;
      int i, opens;
      logic prev_u;
      add(1'b1, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0);
      add(1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0);
      add(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b1);
      add_code(4'b1011);
      add_idle(9);
      add_code(4'b0000);
      add_idle(1);
      add_code(4'b0000);
      add_idle(1);
      add_code(4'b0000);
      add_idle(5);
      add(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b1);
      add_idle(1);
      i = 0;
      opens = 0;
      prev_u = unlocked;
      while (stim_q.size() > 0) begin
         s = stim_q.pop_front();
         drive(s);
         e = exp_q.pop_front();
         n_checks++;
         if (dut_vec() !== e) $display("FAIL reset_mid step %0d: got %b expected %b", i, dut_vec(), e);
         else n_pass++;
         if (s.rst) begin
            n_checks++;
            if (dut_vec() !== '0) $display("FAIL reset_mid_zero step %0d: got %b expected 0", i, dut_vec());
            else n_pass++;
         end
         if (unlocked === 1'b1 && prev_u !== 1'b1) opens++;
         prev_u = unlocked;
         i++;
      end
      n_checks++;
      if (opens !== 1) $display("FAIL reset_code_restore: got %0d opens expected 1", opens);
      else n_pass++;
   endtask

   task automatic test_random();
      stim_t s;
      logic [OW-1:0] e;
      for (int i = 0; i < 600; i++) begin
         s.bv  = ($urandom_range(0, 2) != 0);
         s.bi  = ($urandom_range(0, 1) != 0) ? m_code[3 - m_bits.size()] : 1'($urandom_range(0, 1));
         s.ab  = ($urandom_range(0, 19) == 0);
         s.pe  = ($urandom_range(0, 7) == 0);
         s.pc  = 4'($urandom_range(0, 15));
         s.rst = ($urandom_range(0, 249) == 0);
         drive(s);
         e = exp_q.pop_front();
         n_checks++;
         if (dut_vec() !== e) $display("FAIL random step %0d: got %b expected %b", i, dut_vec(), e);
         else n_pass++;
      end
   endtask

   initial begin
      test_reset();
      test_unlock();
      test_fail_lockout();
      test_abort();
      test_program();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
